// File: rtl/add_tree_acc.sv
// add_tree_acc: signed adder tree with a group accumulator behind it.
// N_IN operands go through a registered binary tree of ceil(log2(N_IN))
// levels. The tree result is then summed over a framed group of beats,
// with the bias added when the group starts.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           input beat valid
//   in_first, in_last  group framing flags (ignored when in_valid=0)
//   in_data            N_IN packed operands, element i = in_data[i*WIDTH +: WIDTH]
//   bias               sampled when a group's first beat reaches the accumulator
//   out_valid          one-cycle pulse when a group result is available
//   out_data           group result, held until the next out_valid
module add_tree_acc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 26,
    parameter int unsigned SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [WIDTH-1:0]        bias,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data
);

    localparam int unsigned L     = $clog2(N_IN);
    localparam int unsigned N_PAD = 1 << L;
    localparam int unsigned N_SRC = 2 * N_PAD - 1;
    localparam int unsigned ROOT  = 2 * N_PAD - 2;

    // Signed add, clamped when SAT!=0, otherwise modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if ((SAT != 0) && (s[WIDTH] != s[WIDTH-1])) begin
            sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[WIDTH-1:0];
        end
    endfunction

    // Node storage: leaves 0..N_PAD-1 (zero padded), then each tree level in
    // turn. Node N_PAD+i has children 2i and 2i+1, which reproduces the
    // pairing (2j, 2j+1) at every level and adds an odd trailing element to 0.
    logic [WIDTH-1:0] src    [N_SRC];
    logic [WIDTH-1:0] node_q [N_PAD-1];

    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            src[i] = '0;
        end
        for (int i = 0; i < int'(N_IN); i++) begin
            src[i] = in_data[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < int'(N_PAD) - 1; i++) begin
            src[int'(N_PAD) + i] = node_q[i];
        end
    end

    // Tree registers: load every cycle, no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_PAD) - 1; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_PAD) - 1; i++) begin
                node_q[i] <= sat_add(src[2*i], src[2*i+1]);
            end
        end
    end

    // Valid/framing flags travel alongside the tree data.
    logic [L-1:0] vld_sr;
    logic [L-1:0] first_sr;
    logic [L-1:0] last_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            vld_sr[0]   <= in_valid;
            first_sr[0] <= in_valid & in_first;
            last_sr[0]  <= in_valid & in_last;
            for (int i = 1; i < int'(L); i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    logic             t_vld;
    logic             t_first;
    logic             t_last;
    logic             open_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base_c;
    logic [WIDTH-1:0] acc_next_c;

    assign t_vld   = vld_sr[L-1];
    assign t_first = first_sr[L-1];
    assign t_last  = last_sr[L-1];

    // A first flag, or no open group, restarts from the live bias value.
    always_comb begin
        acc_base_c = acc_q;
        if (t_first || !open_q) begin
            acc_base_c = bias;
        end
        acc_next_c = sat_add(acc_base_c, src[ROOT]);
    end

    // Accumulator, open-group bit and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            open_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= t_vld & t_last;
            if (t_vld) begin
                acc_q  <= acc_next_c;
                open_q <= !t_last;
                if (t_last) begin
                    out_data <= acc_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_tree_acc.sv
module tb_add_tree_acc;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N_IN  = 26;
    localparam int unsigned L     = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [WIDTH-1:0]      bias;
    logic                  ov_s, ov_w;
    logic [WIDTH-1:0]      od_s, od_w;

    always #5 clk = ~clk;

    add_tree_acc #(.WIDTH(WIDTH), .N_IN(N_IN), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .bias(bias),
        .out_valid(ov_s), .out_data(od_s)
    );

    add_tree_acc #(.WIDTH(WIDTH), .N_IN(N_IN), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .bias(bias),
        .out_valid(ov_w), .out_data(od_w)
    );

    typedef struct {
        bit v;
        bit f;
        bit l;
        int s_sat;
        int s_wrap;
    } beat_t;

    // Reference state: index 0 = saturating, 1 = wrapping.
    int          m_acc  [2];
    bit          m_open [2];
    bit          m_v    [2];
    logic [15:0] m_d    [2];
    beat_t       pipe_q [$];

    int cur [N_IN];
    int cur_bias;
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_d [$];
    int obs_c [$];
    int obs_w [$];

    function automatic int add_m(input int a, input int b, input bit sat);
        int s;
        s = a + b;
        if (sat) begin
            if (s > 32767)  return 32767;
            if (s < -32768) return -32768;
            return s;
        end
        s = s & 32'hFFFF;
        if (s > 32767) s = s - 65536;
        return s;
    endfunction

    // Pairwise reduction of cur[], saturating/wrapping at every node.
    function automatic int tree_m(input bit sat);
        int arr [64];
        int n;
        int m;
        int b;
        for (int i = 0; i < int'(N_IN); i++) arr[i] = cur[i];
        n = int'(N_IN);
        while (n > 1) begin
            m = (n + 1) / 2;
            for (int j = 0; j < m; j++) begin
                b = (2*j + 1 < n) ? arr[2*j+1] : 0;
                arr[j] = add_m(arr[2*j], b, sat);
            end
            n = m;
        end
        return arr[0];
    endfunction

    function automatic int rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        for (int m = 0; m < 2; m++) begin
            m_acc[m] = 0; m_open[m] = 0; m_v[m] = 0; m_d[m] = 16'h0;
        end
    endtask

    task automatic model_proc(input beat_t b, input int bv);
        int t;
        int base;
        for (int m = 0; m < 2; m++) begin
            if (b.v) begin
                t = (m == 0) ? b.s_sat : b.s_wrap;
                base = (b.f || !m_open[m]) ? bv : m_acc[m];
                m_acc[m]  = add_m(base, t, m == 0);
                m_open[m] = !b.l;
                m_v[m]    = b.l;
                if (b.l) m_d[m] = 16'(m_acc[m]);
            end
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic step(input bit v, input bit f, input bit l);
        beat_t nb;
        in_valid = v; in_first = f; in_last = l;
        bias = 16'(cur_bias);
        for (int i = 0; i < int'(N_IN); i++) in_data[i*WIDTH +: WIDTH] = 16'(cur[i]);
        nb.v = v; nb.f = f; nb.l = l;
        nb.s_sat  = tree_m(1'b1);
        nb.s_wrap = tree_m(1'b0);
        pipe_q.push_back(nb);
        @(posedge clk);
        cyc++;
        m_v[0] = 0; m_v[1] = 0;
        if (pipe_q.size() > int'(L)) begin
            nb = pipe_q.pop_front();
            model_proc(nb, cur_bias);
        end
        @(negedge clk);
        chk("valid_sat",  int'(ov_s), int'(m_v[0]));
        chk("data_sat",   int'(od_s), int'(m_d[0]));
        chk("valid_wrap", int'(ov_w), int'(m_v[1]));
        chk("data_wrap",  int'(od_w), int'(m_d[1]));
        if (ov_s) begin obs_d.push_back(int'(od_s)); obs_c.push_back(cyc); end
        if (ov_w) obs_w.push_back(int'(od_w));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < int'(N_IN); i++) cur[i] = val;
    endtask

    task automatic clr_obs();
        obs_d.delete(); obs_c.delete(); obs_w.delete();
    endtask

    // Asynchronous reset asserted mid low phase; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_valid_sat", int'(ov_s), 0);
        chk("rst_data_sat",  int'(od_s), 0);
        chk("rst_valid_wrap", int'(ov_w), 0);
        chk("rst_data_wrap",  int'(od_w), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int beat_cyc;

    initial begin
        rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0;
        in_data = '0; bias = '0; cur_bias = 0;
        fill(0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(ov_s), 0);
        chk("reset_data",  int'(od_s), 0);
        rst_n = 1'b1;
        idle(10);

        // Single-beat group.
        clr_obs(); fill(1); cur_bias = 10;
        step(1, 1, 1); beat_cyc = cyc;
        fill(0); idle(7);
        chk("single_count", obs_d.size(), 1);
        chk("single_data", obs_d.size() > 0 ? obs_d[0] : -1, 36);
        chk("single_latency", obs_c.size() > 0 ? obs_c[0] - beat_cyc + 1 : -1, 6);

        // Multi-beat group with an idle gap.
        clr_obs(); cur_bias = -5;
        fill(2);  step(1, 1, 0);
        fill(3);  step(1, 0, 0);
        idle(1);
        fill(-1); step(1, 0, 1); beat_cyc = cyc;
        idle(7);
        chk("multi_count", obs_d.size(), 1);
        chk("multi_data", obs_d.size() > 0 ? obs_d[0] : -1, 99);
        chk("multi_latency", obs_c.size() > 0 ? obs_c[0] - beat_cyc + 1 : -1, 6);

        // Saturation against wrap on the same stimulus.
        clr_obs(); cur_bias = 0; fill(0);
        cur[0] = 32767; cur[1] = 1;
        step(1, 1, 1); fill(0); idle(7);
        chk("sat_clamp", obs_d.size() > 0 ? obs_d[0] : -1, 32'h7FFF);
        chk("wrap_mod",  obs_w.size() > 0 ? obs_w[0] : -1, 32'h8000);

        // Back-to-back single-beat groups.
        clr_obs(); cur_bias = 1;
        for (int k = 0; k < 8; k++) begin
            fill(k); step(1, 1, 1);
        end
        idle(7);
        chk("stream_count", obs_d.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("stream_data", obs_d.size() > k ? obs_d[k] : -1, 26*k + 1);
            chk("stream_cycle", obs_c.size() > k ? obs_c[k] - obs_c[0] : -1, k);
        end

        // First re-asserted mid-group discards beats 1-2.
        clr_obs(); cur_bias = 0;
        fill(1); step(1, 1, 0);
        step(1, 0, 0);
        fill(2); step(1, 1, 0);
        fill(3); step(1, 0, 1);
        idle(7);
        chk("restart_count", obs_d.size(), 1);
        chk("restart_data", obs_d.size() > 0 ? obs_d[0] : -1, 130);

        // Reset after beat 2 of a 4-beat group: nothing comes out.
        clr_obs();
        fill(5); step(1, 1, 0);
        step(1, 0, 0);
        do_reset();
        idle(8);
        chk("reset_drop_sat",  obs_d.size(), 0);
        chk("reset_drop_wrap", obs_w.size(), 0);

        // Single-beat group after reset.
        clr_obs(); fill(4); cur_bias = 0;
        step(1, 1, 1); fill(0); idle(7);
        chk("post_reset_data", obs_d.size() > 0 ? obs_d[0] : -1, 104);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(N_IN); i++)
                cur[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 200)) - 100 : rnd16();
            cur_bias = rnd16();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
